main_control_mc: RTL and testbench

- Multi-channel successor to the single-channel UART command controller.
- Decodes command bytes from the serial receiver and issues one-cycle start pulses to one of N_CH read/write engines. It then waits for that engine's done, with a timeout, and returns a response byte to the serial transmitter.
- Adds a status command, sticky error flags and overrun detection.

---
 rtl/main_control_mc.sv | 207 ++++++++++++++++++++
 tb/tb_main_control_mc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/main_control_mc.sv
// main_control_mc: multi-channel command controller.
// Decodes command bytes from the serial receiver and starts one of N_CH
// read/write engines. It then waits for that engine's done (with a timeout)
// and hands a response byte to the serial transmitter. A status command
// reports the sticky error flags and clears them.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command byte
// START  | issuing the one-cycle start pulse to the selected engine
// WAIT   | waiting for the matching done, timeout counter running
// REPORT | holding the response until the transmitter is free
module main_control_mc #(
    parameter int         N_CH      = 4,
    parameter int         TO_CYCLES = 1000,
    parameter logic [3:0] CMD_RD    = 4'hA,
    parameter logic [3:0] CMD_WR    = 4'h5,
    parameter logic [3:0] CMD_ST    = 4'hC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rxrdy,
    input  logic [7:0]      rxdw,
    input  logic [N_CH-1:0] done_rd,
    input  logic [N_CH-1:0] done_wr,
    input  logic            txbusy,
    output logic [N_CH-1:0] start_rd,
    output logic [N_CH-1:0] start_wr,
    output logic            txgo,
    output logic [7:0]      txdw,
    output logic            busy,
    output logic            err,
    output logic [2:0]      sleds
);

    // Counter is sized to hold TO_CYCLES; a disabled timeout still gets one bit.
    localparam int CNT_W     = (TO_CYCLES < 1) ? 1 : $clog2(TO_CYCLES + 1);
    localparam int TO_LAST_I = (TO_CYCLES == 0) ? 0 : TO_CYCLES - 1;
    localparam bit TO_EN     = (TO_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       op_q, op_nx;
    logic [3:0]       ch_q, ch_nx;
    logic [7:0]       resp_q, resp_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             to_f, to_nx;
    logic             bad_f, bad_nx;
    logic             ovr_f, ovr_nx;
    logic             last_ok, last_ok_nx;
    logic [N_CH-1:0]  start_rd_nx, start_wr_nx;
    logic             txgo_nx;
    logic [7:0]       txdw_nx;
    logic             busy_nx;
    logic             err_nx;

    logic [N_CH-1:0]  ch_onehot;
    logic             sel_done_rd, sel_done_wr, done_match;
    logic             rx_ch_valid;

    // Channel decode: one-hot of the captured channel and its done bits.
    always_comb begin
        ch_onehot   = '0;
        sel_done_rd = 1'b0;
        sel_done_wr = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (4'(i) == ch_q) begin
                ch_onehot[i] = 1'b1;
                sel_done_rd  = done_rd[i];
                sel_done_wr  = done_wr[i];
            end
        end
        done_match  = (op_q == CMD_RD) ? sel_done_rd : sel_done_wr;
        rx_ch_valid = (int'(rxdw[3:0]) < N_CH);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx    = state;
        op_nx       = op_q;
        ch_nx       = ch_q;
        resp_nx     = resp_q;
        cnt_nx      = cnt_q;
        to_nx       = to_f;
        bad_nx      = bad_f;
        ovr_nx      = ovr_f;
        last_ok_nx  = last_ok;
        start_rd_nx = '0;
        start_wr_nx = '0;
        txgo_nx     = 1'b0;
        txdw_nx     = txdw;

        case (state)
            IDLE: begin
                if (rxrdy) begin
                    op_nx = rxdw[7:4];
                    ch_nx = rxdw[3:0];
                    if ((rxdw[7:4] == CMD_RD || rxdw[7:4] == CMD_WR) && rx_ch_valid) begin
                        state_nx = START;
                    end else if (rxdw[7:4] == CMD_ST) begin
                        // Report the flags as they were, then clear them.
                        resp_nx  = {4'hC, 1'b0, ovr_f, to_f, bad_f};
                        to_nx    = 1'b0;
                        bad_nx   = 1'b0;
                        ovr_nx   = 1'b0;
                        state_nx = REPORT;
                    end else begin
                        bad_nx     = 1'b1;
                        resp_nx    = {4'hB, rxdw[3:0]};
                        last_ok_nx = 1'b0;
                        state_nx   = REPORT;
                    end
                end
            end
            START: begin
                if (op_q == CMD_RD) begin
                    start_rd_nx = ch_onehot;
                end else begin
                    start_wr_nx = ch_onehot;
                end
                cnt_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                // A done arriving on the expiry cycle still counts as success.
                if (done_match) begin
                    resp_nx    = {4'h0, ch_q};
                    last_ok_nx = 1'b1;
                    state_nx   = REPORT;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    to_nx      = 1'b1;
                    resp_nx    = {4'hE, ch_q};
                    last_ok_nx = 1'b0;
                    state_nx   = REPORT;
                end else if (TO_EN) begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            REPORT: begin
                if (!txbusy) begin
                    txgo_nx  = 1'b1;
                    txdw_nx  = resp_q;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A byte arriving while a command is in flight is dropped.
        if (rxrdy && (state != IDLE)) begin
            ovr_nx = 1'b1;
        end

        busy_nx = (state_nx != IDLE);
        // err follows the registered flags, so it lags a flag change by one cycle.
        err_nx  = to_f | bad_f | ovr_f;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= '0;
            ch_q     <= '0;
            resp_q   <= '0;
            cnt_q    <= '0;
            to_f     <= 1'b0;
            bad_f    <= 1'b0;
            ovr_f    <= 1'b0;
            last_ok  <= 1'b0;
            start_rd <= '0;
            start_wr <= '0;
            txgo     <= 1'b0;
            txdw     <= 8'h00;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            op_q     <= op_nx;
            ch_q     <= ch_nx;
            resp_q   <= resp_nx;
            cnt_q    <= cnt_nx;
            to_f     <= to_nx;
            bad_f    <= bad_nx;
            ovr_f    <= ovr_nx;
            last_ok  <= last_ok_nx;
            start_rd <= start_rd_nx;
            start_wr <= start_wr_nx;
            txgo     <= txgo_nx;
            txdw     <= txdw_nx;
            busy     <= busy_nx;
            err      <= err_nx;
        end
    end

    assign sleds = {err, last_ok, busy};

endmodule

// File: tb/tb_main_control_mc.sv
// Directed testbench for main_control_mc (N_CH=4, TO_CYCLES=50).
module tb_main_control_mc;

    localparam int N_CH = 4;

    logic            clk;
    logic            rst;
    logic            rxrdy;
    logic [7:0]      rxdw;
    logic [N_CH-1:0] done_rd;
    logic [N_CH-1:0] done_wr;
    logic            txbusy;
    logic [N_CH-1:0] start_rd;
    logic [N_CH-1:0] start_wr;
    logic            txgo;
    logic [7:0]      txdw;
    logic            busy;
    logic            err;
    logic [2:0]      sleds;

    int n_tests = 0;
    int n_fail  = 0;
    int n_lat;

    main_control_mc #(
        .N_CH      (N_CH),
        .TO_CYCLES (50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxrdy    (rxrdy),
        .rxdw     (rxdw),
        .done_rd  (done_rd),
        .done_wr  (done_wr),
        .txbusy   (txbusy),
        .start_rd (start_rd),
        .start_wr (start_wr),
        .txgo     (txgo),
        .txdw     (txdw),
        .busy     (busy),
        .err      (err),
        .sleds    (sleds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rxrdy = 1'b1;
        rxdw  = b;
        tick();
        rxrdy = 1'b0;
        rxdw  = 8'h00;
    endtask

    task automatic pulse_done(input logic [N_CH-1:0] rd, input logic [N_CH-1:0] wr);
        done_rd = rd;
        done_wr = wr;
        tick();
        done_rd = '0;
        done_wr = '0;
    endtask

    // Waits (bounded) for txgo, checks the byte and that txgo drops next cycle.
    task automatic wait_tx(input string tag, input logic [7:0] exp, output int n);
        n = 0;
        while (txgo !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_eq({tag, "_txgo"}, 32'(txgo), 32'd1);
        check_eq({tag, "_txdw"}, 32'(txdw), 32'(exp));
        tick();
        check_eq({tag, "_txgo_len"}, 32'(txgo), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst     = 1'b0;
        rxrdy   = 1'b0;
        rxdw    = 8'h00;
        done_rd = '0;
        done_wr = '0;
        txbusy  = 1'b0;
        repeat (3) tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_txdw", 32'(txdw), 32'h00);
        check_eq("rst_sleds", 32'(sleds), 32'd0);
        check_eq("rst_start", 32'({start_rd, start_wr}), 32'd0);
        rst = 1'b1;
        tick();

        // Read on channel 0.
        send(8'hA0);
        check_eq("rd_start_early", 32'(start_rd), 32'd0);
        check_eq("rd_busy", 32'(busy), 32'd1);
        tick();
        check_eq("rd_start_pulse", 32'(start_rd), 32'b0001);
        check_eq("rd_start_wr", 32'(start_wr), 32'd0);
        tick();
        check_eq("rd_start_end", 32'(start_rd), 32'd0);
        repeat (17) tick();
        pulse_done(4'b0001, 4'b0000);
        wait_tx("rd", 8'h00, n_lat);
        check_eq("rd_sleds", 32'(sleds), 32'b010);

        // Write on channel 2 with distractor dones.
        send(8'h52);
        tick();
        check_eq("wr_start_pulse", 32'(start_wr), 32'b0100);
        check_eq("wr_start_rd", 32'(start_rd), 32'd0);
        tick();
        pulse_done(4'b0100, 4'b0010);
        tick();
        check_eq("wr_distract_busy", 32'(busy), 32'd1);
        check_eq("wr_distract_txgo", 32'(txgo), 32'd0);
        pulse_done(4'b0000, 4'b0100);
        wait_tx("wr", 8'h02, n_lat);

        // Timeout on channel 1: WAIT entered at edge k+1, expiry at k+51, txgo at k+52.
        send(8'hA1);
        wait_tx("to", 8'hE1, n_lat);
        check_eq("to_latency", 32'(n_lat), 32'd52);
        check_eq("to_err", 32'(err), 32'd1);
        check_eq("to_sleds", 32'(sleds), 32'b100);

        // Done on the expiry cycle wins.
        send(8'hA1);
        repeat (50) tick();
        pulse_done(4'b0010, 4'b0000);
        wait_tx("to_tie", 8'h01, n_lat);
        check_eq("to_tie_latency", 32'(n_lat), 32'd1);

        // Bad commands and status.
        do_reset();
        send(8'h57);
        check_eq("bad_start", 32'({start_rd, start_wr}), 32'd0);
        wait_tx("bad57", 8'hB7, n_lat);
        check_eq("bad57_latency", 32'(n_lat), 32'd1);
        check_eq("bad_no_start", 32'({start_rd, start_wr}), 32'd0);
        send(8'h33);
        wait_tx("bad33", 8'hB3, n_lat);
        check_eq("bad_err", 32'(err), 32'd1);
        send(8'hC0);
        wait_tx("st1", 8'hC1, n_lat);
        check_eq("st1_err", 32'(err), 32'd0);

        // Overrun during WAIT, then transmitter back-pressure.
        send(8'hA1);
        tick();
        tick();
        send(8'hA2);
        for (int i = 0; i < 3; i++) begin
            check_eq("ovr_no_start", 32'(start_rd), 32'd0);
            tick();
        end
        txbusy = 1'b1;
        pulse_done(4'b0010, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            check_eq("txbusy_hold", 32'(txgo), 32'd0);
            tick();
        end
        txbusy = 1'b0;
        wait_tx("txbusy", 8'h01, n_lat);
        check_eq("txbusy_latency", 32'(n_lat), 32'd1);
        check_eq("ovr_err", 32'(err), 32'd1);
        send(8'hC0);
        wait_tx("st2", 8'hC4, n_lat);

        // Asynchronous reset mid-WAIT.
        send(8'hA3);
        repeat (5) tick();
        send(8'hA0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_txdw", 32'(txdw), 32'h00);
        check_eq("mid_rst_sleds", 32'(sleds), 32'd0);
        check_eq("mid_rst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b1;
        pulse_done(4'b1000, 4'b0000);
        repeat (3) tick();
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_txgo", 32'(txgo), 32'd0);
        send(8'h53);
        tick();
        check_eq("post_rst_start", 32'(start_wr), 32'b1000);
        repeat (4) tick();
        pulse_done(4'b0000, 4'b1000);
        wait_tx("post_rst", 8'h03, n_lat);
        check_eq("post_rst_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
